ps2_key_buffer: RTL and testbench
=================================

# ps2_key_buffer

Sits between `PS2_controller` and the LCD character sequencer. It turns raw PS/2 scan-code events into case-tagged key codes and queues them in a show-ahead FIFO, so the sequencer can drain characters at LCD speed without losing keystrokes. It also owns the Shift and Caps Lock state, so downstream logic sees only printable-key make events.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; must be a power of two, minimum 2.

Ports:
- `Clock_50`  in  1  system clock, 50 MHz.
- `Reset`  in  1  asynchronous, active-high reset.
- `PS2_code`  in  9  bits [7:0] are the scan code; bit [8] is the extended (E0-prefixed) flag.
- `PS2_code_ready`  in  1  level from `PS2_controller`; a new event is its rising edge.
- `PS2_make_code`  in  1  1 = make, 0 = break; qualifies the current `PS2_code`.
- `Key_code`  out  9  FIFO head; `{upper_case, scan[7:0]}`.
- `Key_valid`  out  1  FIFO non-empty; `Key_code` is meaningful.
- `Key_pop`  in  1  consumer accepts the head this cycle; ignored when `Key_valid`=0.
- `Flush`  in  1  synchronous FIFO clear.
- `Fifo_count`  out  $clog2(DEPTH)+1  number of occupied entries.
- `Overflow`  out  1  sticky; set when a push is attempted while full.
- `Shift_active`  out  1  either Shift key is held.
- `Caps_lock`  out  1  Caps Lock toggle state.

## Operation
- **Event detection.** `ready_buf` registers `PS2_code_ready`. An event is `PS2_code_ready & ~ready_buf`, so exactly one event occurs per rising edge.
- **Shift keys.** Left Shift `8'h12` and right Shift `8'h59` with bit8=0. Make sets `lshift`/`rshift`; break clears it. `Shift_active = lshift | rshift`. Shift events are never pushed.
- **Caps Lock FSM** (`8'h58`, bit8=0), two states:
  - CAPS_IDLE: on make, toggle `Caps_lock` and go to CAPS_HELD.
  - CAPS_HELD: repeated makes (typematic) are ignored; break returns to CAPS_IDLE.
  - Caps events are never pushed.
- **Printable keys.** Make event, bit8=0, not a modifier: push `{Shift_active ^ Caps_lock, PS2_code[7:0]}`. Modifier state used is the value before this event's update.
- **Dropped events.** Break events of other keys are dropped. Extended events (bit8=1) are dropped.
- **FIFO.** `DEPTH` entries, with read/write pointers $clog2(DEPTH)+1 bits wide. Full when the MSBs differ and the rest match; empty when the pointers are equal. Count = wr_ptr − rd_ptr, modulo 2^(width).
- **Push and pop rules:**
  - Push when full: entry discarded, `Overflow` ← 1, pointers unchanged.
  - Push and pop in the same cycle while non-empty: both occur; count unchanged; a full FIFO stays full.
  - Push and pop in the same cycle while empty: the push occurs and the pop is ignored.
- **Flush.** Zeroes both pointers and has priority over a same-cycle push or pop, so that push is lost. Flush does not clear `Overflow`, the modifiers or the Caps FSM.
- **Reset.** All outputs are 0: `Key_code`=0, `Key_valid`=0, `Fifo_count`=0, `Overflow`=0, `Shift_active`=0, `Caps_lock`=0. Caps FSM goes to CAPS_IDLE and `ready_buf`=0.
- **Reset mid-operation.** Asynchronously discards queued data and modifier state. An event whose ready level is still high after reset release is seen as a new rising edge, and is therefore accepted.

## Timing
- **Push latency.** Event at edge k, where `PS2_code_ready` is first sampled high with `ready_buf`=0. The write occurs at edge k. `Key_valid` and `Key_code` are valid after edge k, i.e. one cycle after the ready rise.
- **Head output.** Show-ahead: `Key_code` is driven from the array at `rd_ptr`. It is combinational from registered state, with no input-to-output path.
- **Pop timing.** A pop at edge p presents the next entry after edge p; `Key_valid` falls after p if that entry was the last.
- **Other outputs.** `Fifo_count`, `Overflow`, `Shift_active` and `Caps_lock` update at the same edge as the causing event.
- **Input sampling.** `PS2_code` and `PS2_make_code` are sampled only in the event cycle. They are assumed stable while `PS2_code_ready` is high, which `PS2_controller` guarantees.
- **Throughput.** Throughput is one push and one pop per cycle.

## Structure
- **Package `ps2_pkg`:**
  - Scan-code constants `SC_LSHIFT`=8'h12, `SC_RSHIFT`=8'h59, `SC_CAPS`=8'h58.
  - typedef `key_code_t` (9 bits).
  - enum `caps_state_t` {CAPS_IDLE, CAPS_HELD}.
- **Sub-module `key_fifo`:** synchronous show-ahead FIFO, parameter `DEPTH`, with push/pop/flush and full/empty/count/overflow. It is instantiated once.
- **Top level.** Edge detection, modifier tracking and the Caps FSM live at the top level.

## Test plan
- **Lower-case key.** Make `9'h01C` ('a') → after one cycle `Key_valid`=1, `Key_code`=9'h01C, `Fifo_count`=1; pop → `Key_valid`=0.
- **Shift handling.**
  - Make `9'h012`, then make `9'h01C` → `Key_code`=9'h11C and `Shift_active`=1.
  - Break `9'h012`, then make `9'h01C` → 9'h01C.
- **Caps Lock toggle and typematic.**
  - Make `9'h058` three times (typematic), break, then make `9'h01C` → `Caps_lock`=1 and 9'h11C.
  - With Caps Lock on, Shift + `9'h01C` → 9'h01C.
- **Dropped events.** Break `9'h01C`, and make with bit8=1 (e.g. `9'h175`) → nothing pushed; `Fifo_count` stays 0.
- **Overflow.**
  - 17 makes with DEPTH=16 → `Fifo_count`=16, `Overflow`=1.
  - The head is the first key.
  - Popping all 16 returns keys 1–16 in order.
- **Simultaneity.**
  - Push and pop in the same cycle at count 16 → count stays 16, no overflow.
  - Flush plus push in the same cycle → count 0.
  - Reset asserted mid-stream → all outputs 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key buffer: modifier scan codes,
// the tagged key-code word and the Caps Lock FSM encoding.
package ps2_pkg;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // {upper_case, scan[7:0]}
    typedef logic [8:0] key_code_t;

    typedef enum logic {
        CAPS_IDLE = 1'b0,
        CAPS_HELD = 1'b1
    } caps_state_t;

endpackage

// File: rtl/key_fifo.sv
// Show-ahead FIFO of key codes with push/pop/flush, a sticky overflow flag
// and pointers one bit wider than the address so full and empty are distinct.
module key_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  key_code_t              din,
    input  logic                   pop,
    input  logic                   flush,
    output key_code_t              dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    key_code_t     mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop on an empty FIFO is ignored; a push on a full FIFO only lands
    // when a same-cycle pop frees the slot.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !do_pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Gated so the head reads zero, not stale storage, whenever the FIFO is empty.
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/ps2_key_buffer.sv
// Turns PS/2 scan-code events into case-tagged key codes, tracks Shift and
// Caps Lock, and queues printable make codes for the LCD sequencer.
module ps2_key_buffer
    import ps2_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   Clock_50,
    input  logic                   Reset,
    input  logic [8:0]             PS2_code,
    input  logic                   PS2_code_ready,
    input  logic                   PS2_make_code,
    output key_code_t              Key_code,
    output logic                   Key_valid,
    input  logic                   Key_pop,
    input  logic                   Flush,
    output logic [$clog2(DEPTH):0] Fifo_count,
    output logic                   Overflow,
    output logic                   Shift_active,
    output logic                   Caps_lock,
    output caps_state_t            Caps_state
);

    logic        ready_buf;
    logic        key_event;
    logic        plain;
    logic        lshift;
    logic        rshift;
    logic        caps_ev;
    logic        caps_toggle;
    logic        push;
    logic        fifo_full;
    logic        fifo_empty;
    key_code_t   push_code;
    caps_state_t caps_state;
    caps_state_t caps_next;

    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) ready_buf <= 1'b0;
        else       ready_buf <= PS2_code_ready;
    end

    assign key_event = PS2_code_ready & ~ready_buf;
    assign plain     = key_event & ~PS2_code[8];
    assign caps_ev   = plain & (PS2_code[7:0] == SC_CAPS);

    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            lshift <= 1'b0;
            rshift <= 1'b0;
        end else begin
            if (plain && PS2_code[7:0] == SC_LSHIFT) lshift <= PS2_make_code;
            if (plain && PS2_code[7:0] == SC_RSHIFT) rshift <= PS2_make_code;
        end
    end

    assign Shift_active = lshift | rshift;

    // Caps Lock: toggle on the first make, swallow typematic repeats until break.
    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) caps_state <= CAPS_IDLE;
        else       caps_state <= caps_next;
    end

    always_comb begin
        caps_next = caps_state;
        case (caps_state)
            CAPS_IDLE: if (caps_ev && PS2_make_code)  caps_next = CAPS_HELD;
            CAPS_HELD: if (caps_ev && !PS2_make_code) caps_next = CAPS_IDLE;
            default:   caps_next = CAPS_IDLE;
        endcase
    end

    always_comb begin
        caps_toggle = (caps_state == CAPS_IDLE) & caps_ev & PS2_make_code;
    end

    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset)            Caps_lock <= 1'b0;
        else if (caps_toggle) Caps_lock <= ~Caps_lock;
    end

    assign Caps_state = caps_state;

    // Case tag uses modifier state from before this event's update.
    assign push = plain & PS2_make_code
                & (PS2_code[7:0] != SC_LSHIFT)
                & (PS2_code[7:0] != SC_RSHIFT)
                & (PS2_code[7:0] != SC_CAPS);
    assign push_code = {Shift_active ^ Caps_lock, PS2_code[7:0]};

    // Consumer handshake: Key_code is valid whenever Key_valid is high; the
    // head is consumed at a clock edge where Key_valid and Key_pop are both 1.
    key_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (Clock_50),
        .rst      (Reset),
        .push     (push),
        .din      (push_code),
        .pop      (Key_pop),
        .flush    (Flush),
        .dout     (Key_code),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (Fifo_count),
        .overflow (Overflow)
    );

    assign Key_valid = ~fifo_empty;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_ps2_key_buffer.sv
// Directed bench for ps2_key_buffer: a queue-based model checked every cycle
// plus literal expectations for the key scenarios.
module tb_ps2_key_buffer;
    import ps2_pkg::*;

    localparam int DEPTH = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [8:0]             ps2_code = '0;
    logic                   ps2_ready = 1'b0;
    logic                   ps2_make = 1'b0;
    key_code_t              key_code;
    logic                   key_valid;
    logic                   key_pop = 1'b0;
    logic                   flush = 1'b0;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   overflow;
    logic                   shift_active;
    logic                   caps_lock;
    caps_state_t            caps_state;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    // model state
    logic [8:0] m_q[$];
    bit m_ls, m_rs, m_caps, m_caps_down, m_ovf;

    ps2_key_buffer #(.DEPTH(DEPTH)) dut (
        .Clock_50       (clk),
        .Reset          (rst),
        .PS2_code       (ps2_code),
        .PS2_code_ready (ps2_ready),
        .PS2_make_code  (ps2_make),
        .Key_code       (key_code),
        .Key_valid      (key_valid),
        .Key_pop        (key_pop),
        .Flush          (flush),
        .Fifo_count     (fifo_count),
        .Overflow       (overflow),
        .Shift_active   (shift_active),
        .Caps_lock      (caps_lock),
        .Caps_state     (caps_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ls = 0; m_rs = 0; m_caps = 0; m_caps_down = 0; m_ovf = 0;
    endtask

    // Applies one clock edge worth of behaviour from the key/FIFO rules.
    task automatic model_step(input bit ev, input logic [8:0] code, input bit make,
                              input bit pop, input bit fl);
        bit push_req = 0;
        bit pop_ok;
        logic [8:0] entry = '0;
        if (ev && !code[8]) begin
            case (code[7:0])
                8'h12: m_ls = make;
                8'h59: m_rs = make;
                8'h58: begin
                    if (make && !m_caps_down) m_caps = !m_caps;
                    m_caps_down = make;
                end
                default: if (make) begin
                    push_req = 1;
                    entry = {(m_ls | m_rs) ^ m_caps, code[7:0]};
                end
            endcase
        end
        if (fl) begin
            m_q.delete();
        end else begin
            pop_ok = pop && (m_q.size() > 0);
            if (pop_ok) void'(m_q.pop_front());
            if (push_req) begin
                if (m_q.size() >= DEPTH) m_ovf = 1;
                else m_q.push_back(entry);
            end
        end
    endtask

    task automatic cycle(input bit ev, input logic [8:0] code, input bit make,
                         input bit pop, input bit fl);
        @(negedge clk); #1;
        if (ev) begin
            ps2_code = code;
            ps2_make = make;
            ps2_ready = 1'b1;
        end
        key_pop = pop;
        flush = fl;
        @(posedge clk);
        model_step(ev, code, make, pop, fl);
        @(negedge clk); #1;
        ps2_ready = 1'b0;
        key_pop = 1'b0;
        flush = 1'b0;
    endtask

    task automatic key(input logic [8:0] code, input bit make);
        cycle(1, code, make, 0, 0);
    endtask

    task automatic pop1();
        cycle(0, '0, 0, 1, 0);
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid", key_valid, m_q.size() != 0);
            if (m_q.size() != 0) chk("head", key_code, m_q[0]);
            chk("count", fifo_count, m_q.size());
            chk("overflow", overflow, m_ovf);
            chk("shift", shift_active, m_ls | m_rs);
            chk("caps", caps_lock, m_caps);
        end
    end

    initial begin
        model_reset();
        #23;
        chk("rst_valid", key_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_code", key_code, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_shift", shift_active, 0);
        chk("rst_caps", caps_lock, 0);
        @(negedge clk); #1;
        rst = 1'b0;
        cmp_en = 1;

        // lower-case key
        key(9'h01C, 1);
        chk("a_valid", key_valid, 1);
        chk("a_code", key_code, 9'h01C);
        chk("a_count", fifo_count, 1);
        pop1();
        chk("a_popped", key_valid, 0);

        // shift
        key(9'h012, 1);
        key(9'h01C, 1);
        chk("shift_code", key_code, 9'h11C);
        chk("shift_act", shift_active, 1);
        pop1();
        key(9'h012, 0);
        key(9'h01C, 1);
        chk("unshift_code", key_code, 9'h01C);
        pop1();

        // caps lock with typematic repeats
        key(9'h058, 1);
        key(9'h058, 1);
        key(9'h058, 1);
        key(9'h058, 0);
        key(9'h01C, 1);
        chk("caps_on", caps_lock, 1);
        chk("caps_code", key_code, 9'h11C);
        pop1();
        key(9'h059, 1);
        key(9'h01C, 1);
        chk("caps_shift_code", key_code, 9'h01C);
        pop1();
        key(9'h059, 0);
        key(9'h058, 1);
        key(9'h058, 0);
        chk("caps_off", caps_lock, 0);

        // dropped events
        key(9'h01C, 0);
        key(9'h175, 1);
        chk("dropped_count", fifo_count, 0);

        // overflow: 17 makes
        for (int i = 0; i < 17; i++) key({1'b0, 8'h20 + 8'(i)}, 1);
        chk("ovf_count", fifo_count, 16);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", key_code, 9'h020);
        for (int i = 0; i < 16; i++) begin
            chk("drain_order", key_code, {1'b0, 8'h20 + 8'(i)});
            pop1();
        end
        chk("drained", key_valid, 0);

        // reset mid-stream, asynchronous
        key(9'h012, 1);
        key(9'h031, 1);
        key(9'h032, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", key_valid, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_code", key_code, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_shift", shift_active, 0);
        chk("arst_caps", caps_lock, 0);
        model_reset();
        @(negedge clk); #1;
        rst = 1'b0;

        // push+pop at full
        for (int i = 0; i < 16; i++) key({1'b0, 8'h40 + 8'(i)}, 1);
        cycle(1, 9'h050, 1, 1, 0);
        chk("pp_full_count", fifo_count, 16);
        chk("pp_full_ovf", overflow, 0);
        chk("pp_full_head", key_code, 9'h041);

        // flush plus push
        cycle(1, 9'h051, 1, 0, 1);
        chk("flush_count", fifo_count, 0);
        chk("flush_valid", key_valid, 0);

        // push and pop while empty
        cycle(1, 9'h052, 1, 1, 0);
        chk("pp_empty_count", fifo_count, 1);
        chk("pp_empty_code", key_code, 9'h052);

        // ready still high at reset release is a fresh event
        @(negedge clk); #1;
        rst = 1'b1;
        model_reset();
        ps2_code = 9'h01C;
        ps2_make = 1'b1;
        ps2_ready = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        model_step(1, 9'h01C, 1, 0, 0);
        @(negedge clk); #1;
        ps2_ready = 1'b0;
        chk("rel_valid", key_valid, 1);
        chk("rel_code", key_code, 9'h01C);
        pop1();
        repeat (2) @(negedge clk);

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
